// File: rtl/hsk_pkg.sv
// hsk_pkg: shared constants, FSM state encodings and clog2 helper for the Pi handshake transmitter
package hsk_pkg;
    localparam int BYTE_W = 8;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETUP    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/hsk_tx_fifo.sv
// hsk_tx_fifo: DEPTH-entry byte FIFO; ports: i_clk, i_reset (async), i_wr_en/i_wr_data (write),
// i_rd_en (pop), o_rd_data (combinational head), o_full, o_empty
module hsk_tx_fifo
    import hsk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [BYTE_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = clog2(DEPTH);
    // one extra pointer bit distinguishes full from empty when the indices match
    logic [AW:0]       r_wr_ptr, r_rd_ptr;
    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic              w_wr, w_rd;
    assign o_empty   = r_wr_ptr == r_rd_ptr;
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
endmodule

// File: rtl/pi_hsk_tx.sv
// pi_hsk_tx: fabric-to-Pi byte transmitter using a toggle handshake; ports: i_clk, i_reset (async),
// i_in_data/i_in_valid/o_in_ready (fabric side), i_pi_hsk_raw (Pi ack), o_pi_data/o_fpga_hsk (to Pi),
// o_busy, o_tx_err (sticky ack timeout), i_clear_err
module pi_hsk_tx
    import hsk_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [BYTE_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_pi_hsk_raw,
    output logic [BYTE_W-1:0] o_pi_data,
    output logic              o_fpga_hsk,
    output logic              o_busy,
    output logic              o_tx_err,
    input  logic              i_clear_err
);
    localparam int SW = clog2(SETUP_CYCLES) + 1;
    localparam int TW = clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYCLES - 1);
    // with the timeout disabled this becomes all ones, so the counter just saturates
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = TIMEOUT_CYCLES != 0;
    logic [1:0]        r_sync;
    logic [1:0]        r_state;
    logic [SW-1:0]     r_setup_cnt;
    logic [TW-1:0]     r_to_cnt;
    logic              r_hsk, r_err;
    logic [BYTE_W-1:0] r_data;
    logic [BYTE_W-1:0] w_fifo_data;
    logic              w_full, w_empty, w_pop, w_ack, w_to_hit, w_pi_hsk_s;
    hsk_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (i_in_valid),
        .i_wr_data (i_in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );
    assign w_pi_hsk_s = r_sync[1];
    assign w_pop      = r_state == ST_IDLE && !w_empty;
    // an echo only counts once the request has actually been toggled
    assign w_ack      = r_state == ST_WAIT_ACK && w_pi_hsk_s == r_hsk;
    assign w_to_hit   = TO_EN && r_state == ST_WAIT_ACK && !w_ack && r_to_cnt == TO_LAST;
    assign o_in_ready = !w_full;
    assign o_pi_data  = r_data;
    assign o_fpga_hsk = r_hsk;
    assign o_tx_err   = r_err;
    assign o_busy     = r_state != ST_IDLE || !w_empty;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync      <= '0;
            r_state     <= ST_IDLE;
            r_setup_cnt <= '0;
            r_to_cnt    <= '0;
            r_hsk       <= 1'b0;
            r_err       <= 1'b0;
            r_data      <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pi_hsk_raw};
            if (w_to_hit) r_err <= 1'b1;
            else if (i_clear_err) r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_data      <= w_fifo_data;
                        r_setup_cnt <= SETUP_LOAD;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_setup_cnt == '0) begin
                        r_hsk    <= !r_hsk;
                        r_to_cnt <= '0;
                        r_state  <= ST_WAIT_ACK;
                    end else begin
                        r_setup_cnt <= r_setup_cnt - 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_ack) r_state <= ST_IDLE;
                    else if (r_to_cnt != TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
